// File: rtl/v_write_back_arb.sv
// Registered vector write-back stage: round-robin ALU/MEM arbitration driving one VRF write port,
// with split (2*VLEN) results written as two consecutive beats to vd and vd+1.
module v_write_back_arb #(
   parameter int unsigned VLEN     = 256,
   parameter int unsigned VREG_AW  = 5,
   parameter int unsigned SPLIT_EN = 1
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 alu_valid_i,
   output logic                 alu_ready_o,
   input  logic                 alu_split_i,
   input  logic [VREG_AW-1:0]   alu_addr_i,
   input  logic [2*VLEN-1:0]    alu_data_i,
   input  logic                 mem_valid_i,
   output logic                 mem_ready_o,
   input  logic                 mem_split_i,
   input  logic [VREG_AW-1:0]   mem_addr_i,
   input  logic [2*VLEN-1:0]    mem_data_i,
   output logic                 vwb_en_o,
   output logic [VREG_AW-1:0]   vwb_addr_o,
   output logic [VLEN-1:0]      vwb_data_o
);

   typedef enum logic {IDLE, BEAT1} state_t;
   typedef enum logic {SRC_ALU, SRC_MEM} src_t;

   state_t               state, next_state;
   src_t                 last_gnt;
   logic                 take_alu, take_mem, accept, split_sel;
   logic [VREG_AW-1:0]   sel_addr;
   logic [2*VLEN-1:0]    sel_data;
   logic [VREG_AW-1:0]   hi_addr;
   logic [VLEN-1:0]      hi_data;

   // Grants are only issued in IDLE and never while reset is asserted.
   always_comb begin
      take_alu   = 1'b0;
      take_mem   = 1'b0;
      next_state = state;
      if (rst_n && state == IDLE) begin
         if (alu_valid_i && mem_valid_i) begin
            if (last_gnt == SRC_ALU) take_mem = 1'b1;
            else                     take_alu = 1'b1;
         end else begin
            take_alu = alu_valid_i;
            take_mem = mem_valid_i;
         end
      end
      accept    = take_alu | take_mem;
      sel_addr  = take_mem ? mem_addr_i : alu_addr_i;
      sel_data  = take_mem ? mem_data_i : alu_data_i;
      split_sel = (take_mem ? mem_split_i : alu_split_i) && (SPLIT_EN != 0);
      case (state)
         IDLE:    if (accept && split_sel) next_state = BEAT1;
         BEAT1:   next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   assign alu_ready_o = take_alu;
   assign mem_ready_o = take_mem;

   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         last_gnt   <= SRC_ALU;
         vwb_en_o   <= 1'b0;
         vwb_addr_o <= '0;
         vwb_data_o <= '0;
         hi_addr    <= '0;
         hi_data    <= '0;
      end else if (accept) begin
         last_gnt   <= take_mem ? SRC_MEM : SRC_ALU;
         vwb_en_o   <= 1'b1;
         vwb_addr_o <= sel_addr;
         vwb_data_o <= sel_data[VLEN-1:0];
         if (split_sel) begin
            hi_addr <= sel_addr + VREG_AW'(1);
            hi_data <= sel_data[2*VLEN-1:VLEN];
         end
      end else if (state == BEAT1) begin
         vwb_en_o   <= 1'b1;
         vwb_addr_o <= hi_addr;
         vwb_data_o <= hi_data;
      end else begin
         vwb_en_o   <= 1'b0;
      end
   end

endmodule

// File: tb/tb_v_write_back_arb.sv
// Bench for v_write_back_arb: two instances (SPLIT_EN=1 and SPLIT_EN=0) checked every cycle
// against a write-queue reference model, with directed scenarios followed by random traffic.
module tb_v_write_back_arb;

   localparam int unsigned VLEN = 256;
   localparam int unsigned AW   = 5;

   logic clk = 1'b0;
   logic rst_n;
   logic              alu_valid [2], alu_split [2], mem_valid [2], mem_split [2];
   logic [AW-1:0]     alu_addr [2], mem_addr [2];
   logic [2*VLEN-1:0] alu_data [2], mem_data [2];
   logic              alu_ready [2], mem_ready [2], vwb_en [2];
   logic [AW-1:0]     vwb_addr [2];
   logic [VLEN-1:0]   vwb_data [2];

   always #5 clk = ~clk;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      v_write_back_arb #(.VLEN(VLEN), .VREG_AW(AW), .SPLIT_EN((g == 0) ? 1 : 0)) u_dut (
         .clk(clk), .rst_n(rst_n),
         .alu_valid_i(alu_valid[g]), .alu_ready_o(alu_ready[g]), .alu_split_i(alu_split[g]),
         .alu_addr_i(alu_addr[g]), .alu_data_i(alu_data[g]),
         .mem_valid_i(mem_valid[g]), .mem_ready_o(mem_ready[g]), .mem_split_i(mem_split[g]),
         .mem_addr_i(mem_addr[g]), .mem_data_i(mem_data[g]),
         .vwb_en_o(vwb_en[g]), .vwb_addr_o(vwb_addr[g]), .vwb_data_o(vwb_data[g]));
   end

   // Reference model: each device owns a list of writes still to appear, one per edge.
   typedef struct {logic [AW-1:0] a; logic [VLEN-1:0] d;} wr_t;
   wr_t             pend [2][2];
   int unsigned     cnt [2];
   bit              last_mem [2];
   bit              acc_alu [2], acc_mem [2];
   logic            exp_en [2];
   logic [AW-1:0]   exp_addr [2];
   logic [VLEN-1:0] exp_data [2];

   int checks = 0, errors = 0;
   bit logging = 0;
   int gnt_hist [2][32];
   int gnt_n [2];

   task automatic chk(input string tag, input logic [VLEN-1:0] obs, input logic [VLEN-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2*VLEN-1:0] rnd_wide();
      logic [2*VLEN-1:0] r;
      for (int i = 0; i < int'(2*VLEN/32); i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   task automatic set_alu(input int d, input logic [AW-1:0] a, input logic s, input logic [2*VLEN-1:0] dt);
      alu_valid[d] = 1'b1; alu_addr[d] = a; alu_split[d] = s; alu_data[d] = dt;
   endtask

   task automatic set_mem(input int d, input logic [AW-1:0] a, input logic s, input logic [2*VLEN-1:0] dt);
      mem_valid[d] = 1'b1; mem_addr[d] = a; mem_split[d] = s; mem_data[d] = dt;
   endtask

   task automatic push(input int d, input logic [AW-1:0] a, input logic [VLEN-1:0] dt);
      pend[d][cnt[d]].a = a;
      pend[d][cnt[d]].d = dt;
      cnt[d]++;
   endtask

   // One clock: check readys before the edge, advance the model, check outputs after it.
   task automatic step();
      logic [AW-1:0]     a;
      logic              sp;
      logic [2*VLEN-1:0] dt;
      #2;
      for (int d = 0; d < 2; d++) begin
         acc_alu[d] = 0; acc_mem[d] = 0;
         if (rst_n && cnt[d] == 0) begin
            if (alu_valid[d] && mem_valid[d]) begin
               if (last_mem[d]) acc_alu[d] = 1; else acc_mem[d] = 1;
            end else begin
               acc_alu[d] = alu_valid[d];
               acc_mem[d] = mem_valid[d];
            end
         end
         chk($sformatf("alu_ready[%0d]", d), VLEN'(alu_ready[d]), VLEN'(acc_alu[d]));
         chk($sformatf("mem_ready[%0d]", d), VLEN'(mem_ready[d]), VLEN'(acc_mem[d]));
         if (logging && (acc_alu[d] || acc_mem[d]) && gnt_n[d] < 32) begin
            gnt_hist[d][gnt_n[d]] = acc_mem[d] ? 1 : 0;
            gnt_n[d]++;
         end
      end
      @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            cnt[d] = 0; last_mem[d] = 0;
            exp_en[d] = 0; exp_addr[d] = '0; exp_data[d] = '0;
         end else begin
            if (acc_alu[d] || acc_mem[d]) begin
               a  = acc_mem[d] ? mem_addr[d]  : alu_addr[d];
               sp = acc_mem[d] ? mem_split[d] : alu_split[d];
               dt = acc_mem[d] ? mem_data[d]  : alu_data[d];
               last_mem[d] = acc_mem[d];
               push(d, a, dt[VLEN-1:0]);
               if (sp && d == 0) push(d, AW'((int'(a) + 1) % (1 << AW)), dt[2*VLEN-1:VLEN]);
            end
            if (cnt[d] > 0) begin
               exp_en[d] = 1; exp_addr[d] = pend[d][0].a; exp_data[d] = pend[d][0].d;
               pend[d][0] = pend[d][1];
               cnt[d]--;
            end else begin
               exp_en[d] = 0;
            end
         end
         chk($sformatf("vwb_en[%0d]", d), VLEN'(vwb_en[d]), VLEN'(exp_en[d]));
         chk($sformatf("vwb_addr[%0d]", d), VLEN'(vwb_addr[d]), VLEN'(exp_addr[d]));
         chk($sformatf("vwb_data[%0d]", d), vwb_data[d], exp_data[d]);
         if (acc_alu[d]) alu_valid[d] = 1'b0;
         if (acc_mem[d]) mem_valid[d] = 1'b0;
      end
   endtask

   logic [2*VLEN-1:0] w;
   logic [VLEN-1:0]   a5, lo, hi;

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         alu_valid[d] = 0; alu_split[d] = 0; alu_addr[d] = '0; alu_data[d] = '0;
         mem_valid[d] = 0; mem_split[d] = 0; mem_addr[d] = '0; mem_data[d] = '0;
         cnt[d] = 0; last_mem[d] = 0; exp_en[d] = 0; exp_addr[d] = '0; exp_data[d] = '0;
         gnt_n[d] = 0;
      end
      @(negedge clk);
      step(); step();
      chk("reset_en", VLEN'(vwb_en[0]), '0);
      chk("reset_data", vwb_data[0], '0);
      rst_n = 1'b1;
      step();

      // T1: single ALU write, one-cycle latency
      for (int i = 0; i < int'(VLEN/8); i++) a5[i*8 +: 8] = 8'hA5;
      w = {rnd_wide() >> VLEN, a5};
      for (int d = 0; d < 2; d++) set_alu(d, 5'd3, 1'b0, w);
      step();
      chk("t1_addr", VLEN'(vwb_addr[0]), VLEN'(3));
      chk("t1_data", vwb_data[0], a5);
      step();
      chk("t1_idle_en", VLEN'(vwb_en[0]), '0);

      // T2: tie directly after reset goes to MEM first
      rst_n = 1'b0; step(); rst_n = 1'b1;
      for (int d = 0; d < 2; d++) begin
         set_mem(d, 5'd1, 1'b0, rnd_wide());
         set_alu(d, 5'd2, 1'b0, rnd_wide());
      end
      step();
      chk("t2_first", VLEN'(vwb_addr[0]), VLEN'(1));
      step();
      chk("t2_second", VLEN'(vwb_addr[0]), VLEN'(2));

      // T3: MEM split, ALU waiting behind the second beat
      w = rnd_wide(); lo = w[VLEN-1:0]; hi = w[2*VLEN-1:VLEN];
      for (int d = 0; d < 2; d++) begin
         set_mem(d, 5'd6, 1'b1, w);
         set_alu(d, 5'd9, 1'b0, rnd_wide());
      end
      step();
      chk("t3_lo_addr", VLEN'(vwb_addr[0]), VLEN'(6));
      chk("t3_lo_data", vwb_data[0], lo);
      step();
      chk("t3_hi_addr", VLEN'(vwb_addr[0]), VLEN'(7));
      chk("t3_hi_data", vwb_data[0], hi);
      step();
      chk("t3_alu_after", VLEN'(vwb_addr[0]), VLEN'(9));

      // T4: high beat address wraps 31 -> 0
      w = rnd_wide();
      for (int d = 0; d < 2; d++) set_alu(d, 5'd31, 1'b1, w);
      step();
      chk("t4_lo_addr", VLEN'(vwb_addr[0]), VLEN'(31));
      step();
      chk("t4_wrap_en", VLEN'(vwb_en[0]), VLEN'(1));
      chk("t4_wrap_addr", VLEN'(vwb_addr[0]), VLEN'(0));
      chk("t4_wrap_data", vwb_data[0], w[2*VLEN-1:VLEN]);
      chk("t4_nosplit_en", VLEN'(vwb_en[1]), '0);
      step();

      // T5: reset on the second-beat edge discards the high beat
      for (int d = 0; d < 2; d++) set_mem(d, 5'd4, 1'b1, rnd_wide());
      step();
      rst_n = 1'b0;
      step();
      chk("t5_en", VLEN'(vwb_en[0]), '0);
      chk("t5_addr", VLEN'(vwb_addr[0]), '0);
      rst_n = 1'b1;
      step();
      chk("t5_no_addr5", VLEN'(vwb_en[0]), '0);

      // T6: both sources always valid with split set; grants must alternate
      logging = 1;
      for (int c = 0; c < 8; c++) begin
         for (int d = 0; d < 2; d++) begin
            if (!alu_valid[d]) set_alu(d, AW'($urandom), 1'b1, rnd_wide());
            if (!mem_valid[d]) set_mem(d, AW'($urandom), 1'b1, rnd_wide());
         end
         step();
      end
      logging = 0;
      for (int d = 0; d < 2; d++) begin
         chk($sformatf("t6_first_mem[%0d]", d), VLEN'(gnt_hist[d][0]), VLEN'(1));
         for (int i = 1; i < gnt_n[d]; i++)
            chk($sformatf("t6_alt[%0d][%0d]", d, i), VLEN'(gnt_hist[d][i] != gnt_hist[d][i-1]), VLEN'(1));
      end
      chk("t6_nosplit_grants", VLEN'(gnt_n[1]), VLEN'(8));
      for (int d = 0; d < 2; d++) begin
         alu_valid[d] = 0; mem_valid[d] = 0;
      end
      step(); step();

      // Random traffic with occasional resets
      for (int c = 0; c < 400; c++) begin
         rst_n = ($urandom % 50) != 0;
         for (int d = 0; d < 2; d++) begin
            if (!alu_valid[d] && ($urandom % 3) != 0) set_alu(d, AW'($urandom), 1'($urandom), rnd_wide());
            if (!mem_valid[d] && ($urandom % 3) != 0) set_mem(d, AW'($urandom), 1'($urandom), rnd_wide());
         end
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
